// File: rtl/char_buf_ctrl.sv
// char_buf_ctrl: clear engine, host write port and renderer read port for the
// 256x7 character buffer RAM. Optional macro: CHAR_BUF_FWD_EN (read forwarding).
module char_buf_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 7,
    parameter logic [DATA_W-1:0] CLR_CHAR = DATA_W'('h20)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic              wr_cursor,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_char,
    output logic [ADDR_W-1:0] cursor,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              ram_cea,
    output logic [ADDR_W-1:0] ram_ada,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_ceb,
    output logic              ram_oce,
    output logic [ADDR_W-1:0] ram_adb,
    output logic              ram_reset,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              wr_fire;

    assign clr_busy = (state == CLEAR);
    assign wr_ready = (state == IDLE) && !clr_start;
    assign wr_fire  = wr_valid && wr_ready;

    // Write-port mux: the clear engine owns the port for the whole clear
    always_comb begin
        ram_cea = wr_fire;
        ram_ada = wr_cursor ? cursor : wr_addr;
        ram_din = wr_char;
        if (clr_busy) begin
            ram_cea = 1'b1;
            ram_ada = clr_cnt;
            ram_din = CLR_CHAR;
        end
    end

    // Clear/idle FSM with the clear counter, done pulse and host cursor
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CLEAR;
            clr_cnt  <= '0;
            clr_done <= 1'b0;
            cursor   <= '0;
        end else begin
            clr_done <= 1'b0;
            unique case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == LAST) begin
                        state    <= IDLE;
                        clr_done <= 1'b1;
                        cursor   <= '0;
                    end
                end
                IDLE: begin
                    if (clr_start) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                    end else if (wr_fire) begin
                        cursor <= ram_ada + 1'b1;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    assign ram_ceb   = rd_req;
    assign ram_adb   = rd_addr;
    assign ram_oce   = 1'b1;
    assign ram_reset = reset;

    // Read valid tracks the RAM's one-cycle output register
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_req;
        end
    end

`ifdef CHAR_BUF_FWD_EN
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    // Capture a same-cycle write to the address being read; only updated on
    // a read so rd_data keeps holding between reads like the RAM output does
    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_hit  <= 1'b0;
            fwd_data <= '0;
        end else if (rd_req) begin
            fwd_hit  <= ram_cea && (rd_addr == ram_ada);
            fwd_data <= ram_din;
        end
    end

    assign rd_data = fwd_hit ? fwd_data : ram_dout;
`else
    assign rd_data = ram_dout;
`endif

endmodule

// File: tb/tb_char_buf_ctrl.sv
// Directed self-checking bench for char_buf_ctrl with a behavioural
// bypass-mode simple-dual-port RAM attached to the RAM ports.
module tb_char_buf_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic       wr_cursor = 1'b0;
    logic [7:0] wr_addr = '0;
    logic [6:0] wr_char = '0;
    logic [7:0] cursor;
    logic       clr_start = 1'b0;
    logic       clr_busy;
    logic       clr_done;
    logic       rd_req = 1'b0;
    logic [7:0] rd_addr = '0;
    logic       rd_valid;
    logic [6:0] rd_data;
    logic       ram_cea;
    logic [7:0] ram_ada;
    logic [6:0] ram_din;
    logic       ram_ceb;
    logic       ram_oce;
    logic [7:0] ram_adb;
    logic       ram_reset;
    logic [6:0] ram_dout;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    char_buf_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_cursor (wr_cursor),
        .wr_addr   (wr_addr),
        .wr_char   (wr_char),
        .cursor    (cursor),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .ram_cea   (ram_cea),
        .ram_ada   (ram_ada),
        .ram_din   (ram_din),
        .ram_ceb   (ram_ceb),
        .ram_oce   (ram_oce),
        .ram_adb   (ram_adb),
        .ram_reset (ram_reset),
        .ram_dout  (ram_dout)
    );

    logic [6:0] mem [256];

    always @(posedge clk) begin
        if (ram_cea) mem[ram_ada] <= ram_din;
        if (ram_reset) ram_dout <= '0;
        else if (ram_ceb && ram_oce) ram_dout <= mem[ram_adb];
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic host_wr(input logic cur, input logic [7:0] a,
                           input logic [6:0] ch);
        wr_valid  = 1'b1;
        wr_cursor = cur;
        wr_addr   = a;
        wr_char   = ch;
        #1;
        check("wr_ready", wr_ready, 1);
        step();
        wr_valid = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [7:0] a,
                           input logic [6:0] exp);
        rd_req  = 1'b1;
        rd_addr = a;
        step();
        rd_req = 1'b0;
        check({tag, "_valid"}, rd_valid, 1);
        check(tag, rd_data, exp);
    endtask

    task automatic wait_clear(input string tag);
        int n;
        n = 0;
        while (clr_busy && n < 600) begin
            step();
            n++;
        end
        check({tag, "_len"}, n, 256);
        check({tag, "_done"}, clr_done, 1);
        check({tag, "_cursor"}, cursor, 0);
        step();
        check({tag, "_done_pulse"}, clr_done, 0);
    endtask

    initial begin
        int n;
        step();
        step();
        check("rst_busy", clr_busy, 1);
        check("rst_done", clr_done, 0);
        check("rst_cursor", cursor, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_ram_reset", ram_reset, 1);
        check("ram_oce", ram_oce, 1);
        reset = 1'b0;
        #1;
        check("clr_first_addr", ram_ada, 0);
        check("clr_first_cea", ram_cea, 1);
        check("clr_first_din", ram_din, 7'h20);
        wait_clear("init_clear");

        n = 0;
        for (int i = 0; i < 256; i++) begin
            rd_req  = 1'b1;
            rd_addr = 8'(i);
            step();
            if (rd_valid !== 1'b1 || rd_data !== 7'h20) n++;
        end
        rd_req = 1'b0;
        check("clear_all_bad_reads", n, 0);

        host_wr(1'b1, 8'h00, 7'h41);
        host_wr(1'b1, 8'h00, 7'h42);
        host_wr(1'b1, 8'h00, 7'h43);
        check("cursor_abc", cursor, 3);
        do_read("rd_a", 8'd0, 7'h41);
        do_read("rd_b", 8'd1, 7'h42);
        do_read("rd_c", 8'd2, 7'h43);

        host_wr(1'b0, 8'hFF, 7'h51);
        check("cursor_wrap", cursor, 0);
        host_wr(1'b1, 8'h77, 7'h5A);
        check("cursor_after_wrap", cursor, 1);
        do_read("rd_ff", 8'hFF, 7'h51);
        do_read("rd_00", 8'h00, 7'h5A);
        do_read("rd_01", 8'h01, 7'h42);
        step();
        check("rd_hold_valid", rd_valid, 0);
        check("rd_hold_data", rd_data, 7'h42);

        clr_start = 1'b1;
        wr_valid  = 1'b1;
        wr_cursor = 1'b0;
        wr_addr   = 8'd50;
        wr_char   = 7'h77;
        #1;
        check("clr_wins_ready", wr_ready, 0);
        step();
        clr_start = 1'b0;
        wr_valid  = 1'b0;
        check("clr_busy_rise", clr_busy, 1);
        check("clr_cursor_held", cursor, 1);
        n = 0;
        while (!clr_done && n < 600) begin
            clr_start = (n == 100);
            step();
            n++;
        end
        clr_start = 1'b0;
        check("clr_done_timing", n, 256);
        check("clr_cursor_zero", cursor, 0);
        do_read("rd_cleared0", 8'd0, 7'h20);

        host_wr(1'b0, 8'd5, 7'h61);
        host_wr(1'b0, 8'd6, 7'h62);
        host_wr(1'b0, 8'd7, 7'h63);
        check("cursor_explicit", cursor, 8);
        rd_req  = 1'b1;
        rd_addr = 8'd5;
        step();
        check("b2b_v5", rd_valid, 1);
        check("b2b_d5", rd_data, 7'h61);
        rd_addr = 8'd6;
        step();
        check("b2b_v6", rd_valid, 1);
        check("b2b_d6", rd_data, 7'h62);
        rd_addr = 8'd7;
        step();
        check("b2b_v7", rd_valid, 1);
        check("b2b_d7", rd_data, 7'h63);
        rd_req = 1'b0;
        step();
        check("b2b_vend", rd_valid, 0);
        check("b2b_hold", rd_data, 7'h63);

        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        for (int i = 0; i < 100; i++) step();
        check("mid_clear_addr", ram_ada, 100);
        rd_req  = 1'b1;
        rd_addr = 8'd3;
        reset   = 1'b1;
        step();
        rd_req = 1'b0;
        reset  = 1'b0;
        check("mid_rst_rd_valid", rd_valid, 0);
        check("mid_rst_busy", clr_busy, 1);
        check("mid_rst_addr", ram_ada, 0);
        wait_clear("restart_clear");
        do_read("rd_after_restart", 8'd5, 7'h20);

`ifdef CHAR_BUF_FWD_EN
        wr_valid  = 1'b1;
        wr_cursor = 1'b0;
        wr_addr   = 8'd10;
        wr_char   = 7'h33;
        rd_req    = 1'b1;
        rd_addr   = 8'd10;
        step();
        wr_valid = 1'b0;
        rd_req   = 1'b0;
        check("fwd_valid", rd_valid, 1);
        check("fwd_data", rd_data, 7'h33);
        step();
        check("fwd_hold", rd_data, 7'h33);
        do_read("fwd_reread", 8'd10, 7'h33);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
